// File: rtl/muldiv_unit.sv
// Iterative MIPS-32 multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division, one bit per cycle.
// MTHI/MTLO write HI/LO directly from rs_data.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  typedef enum logic [2:0] {
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO
  } op_t;

  state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic               is_div, neg_q, neg_r, div_zero;
  logic [WIDTH-1:0]   b_q, rs_q, rem;
  logic [2*WIDTH-1:0] acc;

  logic               accept, rs_neg, rt_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum, shifted, trial;
  logic               q_bit;
  logic [2*WIDTH-1:0] prod;

  logic [WIDTH-1:0]   hi_d, lo_d;
  logic               busy_d, done_d;

  // A new mult/div is only taken while idle; MTHI/MTLO/no-ops never start the FSM.
  assign accept = (state == IDLE) && start && !op[2];

  // Operand sign handling: op[0]=0 marks the signed variants (MULT, DIV).
  assign rs_neg = !op[0] && rs_data[WIDTH-1];
  assign rt_neg = !op[0] && rt_data[WIDTH-1];
  assign a_abs  = rs_neg ? -rs_data : rs_data;
  assign b_abs  = rt_neg ? -rt_data : rt_data;

  // One iteration step of both algorithms, computed from the current state.
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? b_q : '0)};
    shifted = {rem, acc[WIDTH-1]};
    trial   = shifted - {1'b0, b_q};
    // The step result stays within (-2^WIDTH, 2^WIDTH), so bit WIDTH is its sign.
    q_bit   = ~trial[WIDTH];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture at acceptance, then one iteration per CALC cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      b_q      <= '0;
      rs_q     <= '0;
      rem      <= '0;
      acc      <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt      <= '0;
          is_div   <= op[1];
          neg_q    <= rs_neg ^ rt_neg;
          neg_r    <= rs_neg;
          div_zero <= (rt_data == '0);
          b_q      <= b_abs;
          rs_q     <= rs_data;
          rem      <= '0;
          acc      <= {{WIDTH{1'b0}}, a_abs};
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            rem             <= q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
            acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], q_bit};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Output logic: next values for the registered hi/lo/busy/done.
  always_comb begin
    hi_d   = hi;
    lo_d   = lo;
    busy_d = 1'b0;
    done_d = 1'b0;
    prod   = neg_q ? -acc : acc;
    case (state)
      IDLE: begin
        if (accept) busy_d = 1'b1;
        else if (start && op == OP_MTHI) hi_d = rs_data;
        else if (start && op == OP_MTLO) lo_d = rs_data;
      end
      CALC: busy_d = 1'b1;
      FIX: begin
        done_d = 1'b1;
        if (is_div && div_zero) begin
          hi_d = rs_q;
          lo_d = '1;
        end else if (is_div) begin
          lo_d = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
          hi_d = neg_r ? -rem : rem;
        end else begin
          {hi_d, lo_d} = prod;
        end
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hi   <= '0;
      lo   <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      hi   <= hi_d;
      lo   <= lo_d;
      busy <= busy_d;
      done <= done_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32).
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;
  logic [31:0] hi, lo;
  logic        busy, done;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] m_hi, m_lo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Start a mult/div at the next edge, then wait (bounded) for done.
  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    logic seen_drop;
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_e0"}, {63'd0, busy}, 64'd1);
    n = 0;
    seen_drop = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      n = i;
      if (i == 16) check({tag, "_hold"}, {hi, lo}, {m_hi, m_lo});
      if (done) break;
      if (!busy) seen_drop = 1'b1;
    end
    check({tag, "_latency"}, 64'(n), 64'd33);
    check({tag, "_busy_gap"}, {63'd0, seen_drop}, 64'd0);
    check({tag, "_result"}, {hi, lo}, {ehi, elo});
    check({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
    m_hi = ehi; m_lo = elo;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; op = 3'b000; rs_data = '0; rt_data = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", {hi, lo}, 64'd0);
    check("reset_flags", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // 1: MULT -3 * 7
    run("mult", 3'b000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
    @(posedge clk); #1;
    check("mult_done_pulse", {63'd0, done}, 64'd0);

    // 2: MULTU max*max
    run("multu", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);

    // 3: DIV -7/2, then DIVU 100/7 started back-to-back in the done cycle
    run("div", 3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run("divu", 3'b011, 32'd100, 32'd7, 32'h00000002, 32'h0000000E);

    // 4: divide by zero and signed overflow
    run("divu_zero", 3'b011, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF);
    run("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run("div_zero_s", 3'b010, 32'hFFFFFFF0, 32'h0, 32'hFFFFFFF0, 32'hFFFFFFFF);

    // 5: MTHI / MTLO in consecutive cycles, then a no-op
    @(negedge clk);
    start = 1'b1; op = 3'b100; rs_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    check("mthi", {hi, lo}, {32'hDEADBEEF, 32'hFFFFFFFF});
    check("mthi_flags", {62'd0, busy, done}, 64'd0);
    op = 3'b101; rs_data = 32'h0BADF00D;
    @(posedge clk); #1;
    check("mtlo", {hi, lo}, {32'hDEADBEEF, 32'h0BADF00D});
    check("mtlo_flags", {62'd0, busy, done}, 64'd0);
    op = 3'b110; rs_data = 32'h55555555; rt_data = 32'h3;
    @(posedge clk); #1;
    op = 3'b111;
    @(posedge clk); #1;
    start = 1'b0;
    check("noop", {hi, lo}, {32'hDEADBEEF, 32'h0BADF00D});
    check("noop_flags", {62'd0, busy, done}, 64'd0);
    m_hi = 32'hDEADBEEF; m_lo = 32'h0BADF00D;

    // 5b: requests while busy are ignored; MULT 16 * -1
    begin
      int n;
      @(negedge clk);
      start = 1'b1; op = 3'b000; rs_data = 32'h10; rt_data = 32'hFFFFFFFF;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      for (int i = 1; i <= 40; i++) begin
        if (i == 5)  begin start = 1'b1; op = 3'b101; rs_data = 32'h11111111; end
        if (i == 10) begin start = 1'b1; op = 3'b001; rs_data = 32'h2; rt_data = 32'h3; end
        @(posedge clk); #1;
        start = 1'b0;
        n = i;
        if (i == 5)  check("ign_mtlo", {hi, lo}, {m_hi, m_lo});
        if (i == 11) check("ign_start", {hi, lo, 31'd0, busy}, {m_hi, m_lo, 32'd1});
        if (done) break;
      end
      check("ign_latency", 64'(n), 64'd33);
      check("ign_result", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFF0});
      @(posedge clk); #1;
      check("ign_after", {62'd0, busy, done}, 64'd0);
    end

    // 6: reset mid-operation
    begin
      logic saw_done;
      @(negedge clk);
      start = 1'b1; op = 3'b001; rs_data = 32'd5; rt_data = 32'd6;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_mid_out", {hi, lo}, 64'd0);
      check("rst_mid_flags", {62'd0, busy, done}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 30; i++) begin
        @(posedge clk); #1;
        if (done || busy) saw_done = 1'b1;
      end
      check("rst_no_done", {63'd0, saw_done}, 64'd0);
      m_hi = '0; m_lo = '0;
      run("multu_after_rst", 3'b001, 32'd5, 32'd6, 32'h0, 32'h0000001E);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative MIPS-32 multiply/divide unit with architectural HI/LO registers, directly downstream of RegisterFile. It consumes rs_out/rt_out as rs_data/rt_data and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Results are held in HI/LO for later MFHI/MFLO reads. A busy/done handshake lets the control path stall while an iteration runs.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
start  input  1  request; sampled only when busy=0.
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are no-ops.
rs_data  input  WIDTH  multiplicand or dividend; also the MTHI/MTLO source.
rt_data  input  WIDTH  multiplier or divisor.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.
busy  output  1  iteration in progress.
done  output  1  single-cycle pulse when HI/LO take a mult/div result.

Behaviour:
- Reset: when rst=0 at a clk edge, hi=0, lo=0, busy=0, done=0, FSM=IDLE, iteration counter=0.
  - Reset overrides everything, including an operation in flight; the partial result is discarded.
- FSM states:
  - IDLE -> CALC on an edge with start=1, busy=0 and op in {000..011}.
  - CALC -> FIX after WIDTH iterations (counter 0..WIDTH-1).
  - FIX -> IDLE unconditionally.
- Operand capture (edge E0, IDLE->CALC):
  - Latch op, rs_data and rt_data.
  - Signed ops (MULT, DIV) latch absolute values and record the result signs.
  - busy=1 from E0.
- CALC (edges E1..E32 for WIDTH=32): one step per edge.
  - Multiply: shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle, with a (WIDTH+1)-bit partial remainder.
- FIX (edge E33): apply sign correction, write hi/lo, done=1 for exactly one cycle, busy=0. Latency from the start-accepting edge to visible results is WIDTH+1 edges.
- MULT/MULTU result: {hi,lo} = full 2*WIDTH product, two's complement for MULT.
- DIV/DIVU result: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero.
  - Signed remainder takes the sign of the dividend.
- Divide by zero (DIV or DIVU with rt_data=0): lo = all ones, hi = original rs_data. Same latency; done still pulses.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No exception is raised.
- MTHI/MTLO with start=1, busy=0: hi (or lo) <= rs_data on that edge. No busy, no done, FSM stays IDLE.
- Ignored requests (no state change):
  - start while busy=1, for any op; the in-flight operation completes unaffected.
  - op 110/111.
- No overlap:
  - start=1 in the same cycle done=1 (busy=0) is accepted normally; back-to-back operations have 1 idle edge min.
  - hi/lo hold their values throughout CALC; they change only at FIX, on MTHI/MTLO, or on reset.
- Outputs are registered; there is no combinational path from inputs to hi, lo, busy or done.

Test Plan:
1. Reset, then MULT with rs=0xFFFFFFFD (-3), rt=0x00000007 -> busy high 33 cycles; done pulses once; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
2. MULTU with rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 exactly 33 edges after start.
3. DIV with rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU with rs=100, rt=7 -> lo=0x0000000E, hi=0x00000002.
4. DIVU with rs=0x12345678, rt=0 -> lo=0xFFFFFFFF, hi=0x12345678, done pulses. DIV with rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
5. MTHI 0xDEADBEEF, then MTLO 0x0BADF00D in consecutive cycles -> hi/lo update on the next edge each; busy and done stay 0. MULT started, then MTLO and a second start issued at cycle 10 -> both ignored; the original MULT result lands at cycle 33.
6. Start MULTU 5*6, assert rst=0 at cycle 15 for one edge -> hi=lo=0, busy=0, done never pulses. A new MULTU 5*6 afterwards -> lo=0x1E, hi=0.
